// File: rtl/bus_arbiter.sv
// Bus arbiter: grants one of NUM_MASTERS requesters the shared serial bus.
// A tenure runs IDLE -> GRANT -> BUSY -> RELEASE -> IDLE, with grant and
// busy timeouts that force RELEASE and pulse timeout_err.
// Winner selection: fixed priority by default (lowest index wins).
// Define ARB_ROUND_ROBIN_EN to search upward from the last winner instead.
// Ports:
//   clk         - clock, posedge
//   rst         - asynchronous active-high reset
//   m_request   - per-master request lines
//   bus_util    - grantee is using the bus
//   m_grant     - registered one-hot (or zero) grant
//   grant_id    - registered index of current/last grantee
//   timeout_err - one-cycle pulse on grant or busy timeout
//   arb_state   - state encoding for debug
module bus_arbiter #(
  parameter int NUM_MASTERS   = 3,
  parameter int GRANT_TIMEOUT = 16,
  parameter int BUSY_TIMEOUT  = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] m_request,
  input  logic                   bus_util,
  output logic [NUM_MASTERS-1:0] m_grant,
  output logic [2:0]             grant_id,
  output logic                   timeout_err,
  output logic [1:0]             arb_state
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = $clog2(BUSY_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t                 state, state_n;
  logic [IW-1:0]          gid, gid_n;
  logic [CW-1:0]          cnt;
  logic [NUM_MASTERS-1:0] grant_n;
  logic                   terr_n;
  logic [IW-1:0]          win;
  logic                   any_req;
  logic [IW-1:0]          idx;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr;
`endif

  assign any_req = |m_request;

  // Winner search; the first hit in search order wins.
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
`ifdef ARB_ROUND_ROBIN_EN
      idx = IW'((int'(ptr) + 1 + k) % NUM_MASTERS);
`else
      idx = IW'(k);
`endif
      // Scanning backwards lets the earliest match overwrite later ones.
      if (m_request[idx]) win = idx;
    end
  end

  always_comb begin
    state_n = state;
    gid_n   = gid;
    terr_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_n = GRANT;
          gid_n   = win;
        end
      end
      GRANT: begin
        // bus_util takes precedence over request drop and timeout.
        if (bus_util) begin
          state_n = BUSY;
        end else if (!m_request[gid]) begin
          state_n = RELEASE;
        end else if (cnt == CW'(GRANT_TIMEOUT - 1)) begin
          state_n = RELEASE;
          terr_n  = 1'b1;
        end
      end
      BUSY: begin
        if (!bus_util) begin
          state_n = RELEASE;
        end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
          state_n = RELEASE;
          terr_n  = 1'b1;
        end
      end
      RELEASE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    grant_n = '0;
    if (state_n == GRANT || state_n == BUSY) begin
      grant_n = NUM_MASTERS'(1) << gid_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      gid         <= '0;
      m_grant     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      gid         <= gid_n;
      m_grant     <= grant_n;
      timeout_err <= terr_n;
    end
  end

  // Cycles-in-state counter: cleared on each state entry, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state_n != state) begin
      cnt <= '0;
    end else if (cnt != {CW{1'b1}}) begin
      cnt <= cnt + CW'(1);
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= IW'(NUM_MASTERS - 1);
    end else if (state == IDLE && any_req) begin
      ptr <= win;
    end
  end
`endif

  assign grant_id  = 3'(gid);
  assign arb_state = state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus pushes the expected outputs
// per cycle, a negedge monitor pops and compares them.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] m_request = '0;
  logic       bus_util = 1'b0;
  logic [2:0] m_grant;
  logic [2:0] grant_id;
  logic       timeout_err;
  logic [1:0] arb_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] st;
    logic [2:0] gr;
    logic [2:0] gid;
    logic       te;
    string      tag;
  } exp_t;

  exp_t q[$];
  exp_t e;

  bus_arbiter #(
    .NUM_MASTERS(3),
    .GRANT_TIMEOUT(16),
    .BUSY_TIMEOUT(4096)
  ) dut (
    .clk(clk),
    .rst(rst),
    .m_request(m_request),
    .bus_util(bus_util),
    .m_grant(m_grant),
    .grant_id(grant_id),
    .timeout_err(timeout_err),
    .arb_state(arb_state)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, ".state"}, 32'(arb_state), 32'(e.st));
      chk({e.tag, ".grant"}, 32'(m_grant), 32'(e.gr));
      chk({e.tag, ".gid"}, 32'(grant_id), 32'(e.gid));
      chk({e.tag, ".terr"}, 32'(timeout_err), 32'(e.te));
    end
  end

  task automatic step(input string tag, input logic [2:0] r,
                      input logic u, input logic [1:0] st,
                      input logic [2:0] gr, input logic [2:0] gid,
                      input logic te);
    exp_t x;
    m_request = r;
    bus_util  = u;
    @(posedge clk);
    x.st = st; x.gr = gr; x.gid = gid; x.te = te; x.tag = tag;
    q.push_back(x);
    @(negedge clk);
    #1;
  endtask

  task automatic rst_check(input string tag);
    #1;
    chk({tag, ".rst_state"}, 32'(arb_state), 32'd0);
    chk({tag, ".rst_grant"}, 32'(m_grant), 32'd0);
    chk({tag, ".rst_gid"}, 32'(grant_id), 32'd0);
    chk({tag, ".rst_terr"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] g;
    logic [2:0] oh;

    repeat (2) @(negedge clk);
    rst_check("reset");
    rst = 1'b0;
    #1;

    // Single request from master 1, then request drop in GRANT.
    step("idle", 3'b000, 0, 2'd0, 3'b000, 3'd0, 0);
    step("g1", 3'b010, 0, 2'd1, 3'b010, 3'd1, 0);
    step("g1drop", 3'b000, 0, 2'd3, 3'b000, 3'd1, 0);
    step("g1idle", 3'b000, 0, 2'd0, 3'b000, 3'd1, 0);

    // Master 0 tenure: bus_util rises while request drops; 10 busy cycles.
    step("t0g", 3'b001, 0, 2'd1, 3'b001, 3'd0, 0);
    for (int i = 0; i < 10; i++)
      step("t0busy", 3'b000, 1, 2'd2, 3'b001, 3'd0, 0);
    step("t0rel", 3'b000, 0, 2'd3, 3'b000, 3'd0, 0);
    step("t0idle", 3'b000, 0, 2'd0, 3'b000, 3'd0, 0);

    // Grant timeout: 16 cycles of grant, then RELEASE with one pulse.
    step("gto_g", 3'b100, 0, 2'd1, 3'b100, 3'd2, 0);
    for (int i = 0; i < 15; i++)
      step("gto_hold", 3'b100, 0, 2'd1, 3'b100, 3'd2, 0);
    step("gto_rel", 3'b100, 0, 2'd3, 3'b000, 3'd2, 1);
    step("gto_idle", 3'b000, 0, 2'd0, 3'b000, 3'd2, 0);
    step("gto_idle2", 3'b000, 0, 2'd0, 3'b000, 3'd2, 0);

    // bus_util arriving on the timeout cycle wins.
    step("race_g", 3'b001, 0, 2'd1, 3'b001, 3'd0, 0);
    for (int i = 0; i < 15; i++)
      step("race_hold", 3'b001, 0, 2'd1, 3'b001, 3'd0, 0);
    step("race_busy", 3'b001, 1, 2'd2, 3'b001, 3'd0, 0);
    step("race_rel", 3'b000, 0, 2'd3, 3'b000, 3'd0, 0);
    step("race_idle", 3'b000, 0, 2'd0, 3'b000, 3'd0, 0);

    // Busy timeout: 4096 busy cycles, then forced RELEASE.
    step("bto_g", 3'b010, 0, 2'd1, 3'b010, 3'd1, 0);
    step("bto_b", 3'b010, 1, 2'd2, 3'b010, 3'd1, 0);
    for (int i = 0; i < 4095; i++)
      step("bto_hold", 3'b010, 1, 2'd2, 3'b010, 3'd1, 0);
    step("bto_rel", 3'b010, 1, 2'd3, 3'b000, 3'd1, 1);
    step("bto_idle", 3'b000, 0, 2'd0, 3'b000, 3'd1, 0);

    // Reset pulse, then all masters requesting with 3-cycle tenures.
    rst = 1'b1;
    rst_check("rst2");
    @(negedge clk);
    rst = 1'b0;
    #1;
    g = 3'd0;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      g = 3'(k % 3);
`else
      g = 3'd0;
`endif
      oh = 3'b001 << g;
      step("rr_g", 3'b111, 0, 2'd1, oh, g, 0);
      step("rr_b1", 3'b111, 1, 2'd2, oh, g, 0);
      step("rr_b2", 3'b111, 1, 2'd2, oh, g, 0);
      step("rr_rel", 3'b111, 0, 2'd3, 3'b000, g, 0);
      step("rr_idle", 3'b111, 0, 2'd0, 3'b000, g, 0);
    end
    step("rr_end", 3'b000, 0, 2'd0, 3'b000, g, 0);

    // Reset mid-BUSY drops the grant without a clock edge.
    step("mr_idle", 3'b000, 0, 2'd0, 3'b000, g, 0);
    step("mr_g", 3'b001, 0, 2'd1, 3'b001, 3'd0, 0);
    step("mr_b", 3'b001, 1, 2'd2, 3'b001, 3'd0, 0);
    rst = 1'b1;
    rst_check("midrst");
    @(negedge clk);
    rst = 1'b0;
    bus_util = 1'b0;
    #1;
    step("mr_regrant", 3'b001, 0, 2'd1, 3'b001, 3'd0, 0);
    step("mr_rel", 3'b000, 0, 2'd3, 3'b000, 3'd0, 0);
    step("mr_idle2", 3'b000, 0, 2'd0, 3'b000, 3'd0, 0);

    repeat (2) @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 3: number of requesting masters (2..8).
REQ-002 Parameter GRANT_TIMEOUT, default 16: cycles a grantee has to assert bus_util before the grant is withdrawn.
REQ-003 Parameter BUSY_TIMEOUT, default 4096: maximum cycles one tenure may hold bus_util high.
REQ-004 Port clk  input  1  single clock; all logic on posedge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port m_request  input  NUM_MASTERS  per-master b_request lines; bit i belongs to master i.
REQ-007 Port bus_util  input  1  high while the granted master is utilizing the serial bus.
REQ-008 Port m_grant  output  NUM_MASTERS  one-hot or zero b_grant lines, registered.
REQ-009 Port grant_id  output  3  index of the current or last grantee, registered.
REQ-010 Port timeout_err  output  1  one-cycle pulse when a grant or busy timeout fires.
REQ-011 Port arb_state  output  2  current state encoding, for debug.

Function
REQ-012 The state machine SHALL have four states: IDLE=0, GRANT=1, BUSY=2, RELEASE=3.
REQ-013 In IDLE, when any m_request bit is high, the arbiter SHALL select one winner and set m_grant to that winner's one-hot value on the next edge; it SHALL also load grant_id and enter GRANT (request-to-grant latency is one cycle).
REQ-014 In GRANT, if bus_util=1 the arbiter SHALL enter BUSY with m_grant held.
REQ-015 In GRANT, if bus_util=0 and the grantee's request is low, the arbiter SHALL enter RELEASE.
REQ-016 In GRANT, if GRANT_TIMEOUT cycles pass without bus_util, the arbiter SHALL enter RELEASE and pulse timeout_err.
REQ-017 When bus_util rises in the same cycle that the request drops or the timeout expires, bus_util SHALL win and the arbiter SHALL enter BUSY.
REQ-018 In BUSY, bus_util=0 SHALL cause entry to RELEASE; the grantee's request level SHALL be ignored.
REQ-019 In BUSY, BUSY_TIMEOUT consecutive cycles of bus_util=1 SHALL force entry to RELEASE and pulse timeout_err.
REQ-020 In RELEASE, m_grant SHALL be all zeros for exactly one cycle, after which the arbiter SHALL return to IDLE.
- Minimum gap between two grants is therefore two cycles (RELEASE then IDLE).
REQ-021 The timeout counter SHALL clear on every state entry.
- Counter width is clog2(BUSY_TIMEOUT)+1; it SHALL saturate and never wrap.
REQ-022 m_grant SHALL never have more than one bit set.
REQ-023 m_grant SHALL be zero in every state except GRANT and BUSY.
REQ-024 Request bits at or above NUM_MASTERS do not exist; grant_id SHALL always be less than NUM_MASTERS.

Reset
REQ-025 While rst=1 the arbiter SHALL hold: state IDLE, m_grant=0, grant_id=0, timeout_err=0, counter=0, round-robin pointer=NUM_MASTERS-1.
REQ-026 Asserting rst mid-tenure SHALL drop m_grant immediately without waiting for a clock edge.
REQ-027 After rst deasserts, the first arbitration SHALL happen on the first edge on which any request is high.

Configuration
REQ-028 With macro ARB_ROUND_ROBIN_EN defined, the winner SHALL be the first requesting index found searching upward from pointer+1 modulo NUM_MASTERS; the pointer SHALL load the winner index on entry to GRANT.
REQ-029 With ARB_ROUND_ROBIN_EN undefined, the winner SHALL be the lowest-index requesting master (fixed priority) and no pointer SHALL exist.

Verification
REQ-030 Scenario: rst pulse, then m_request=3'b010 -> m_grant=3'b010 one cycle later and grant_id=1.
REQ-031 Scenario: grant master 0, bus_util high for 10 cycles then low -> m_grant holds 3'b001 for the whole tenure, then reads 0 for 1 cycle; arb_state sequence is 1,2,...,2,3,0.
REQ-032 Scenario: grant with bus_util held at 0 -> m_grant withdrawn after 16 cycles with a single timeout_err pulse.
REQ-033 Scenario: bus_util held at 1 for more than 4096 cycles -> forced RELEASE and one timeout_err pulse.
REQ-034 Scenario: m_request=3'b111 held constantly, each tenure lasts 3 cycles -> round-robin grants order 0,1,2,0; fixed-priority grants are always 0.
REQ-035 Scenario: rst asserted during BUSY -> m_grant=0 in the same cycle; with request still high, re-grant follows one edge after rst deasserts.
